multicycle_control: RTL and testbench

Sequencing controller for the multicycle variant of the MIPS datapath: one shared memory for instructions and data, one ALU that also handles PC increment and branch target, and IR/MDR/A/B/ALUOut holding registers.
- Moore FSM steps each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select and write enable.
- Waits on a memory-ready handshake and counts retired instructions.
- Sits beside the datapath top. It replaces the single-cycle combinational control and the ALU-op generator stays downstream.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 146 ++++++++++++++
 tb/tb_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU/mux select codes and the bundle of datapath control bits.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// every select and write enable out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and counts retirements.
import mips_ctrl_pkg::*;

module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   retire;
  ctrl_t                  ctrl;

  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:         state_next = S_R_EXEC;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LW)      state_next = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_next = S_MEM_WRITE;
        else                          state_next = S_FETCH;
      end
      S_MEM_READ: state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        state_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
        retire     = bus.mem_ready;
      end
      S_R_EXEC:    state_next = S_R_WB;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        count_reg <= count_reg + COUNT_WIDTH'(1);
    end
  end

  // Pure state decode, except the FETCH write enables which follow mem_ready.
  // Holding everything low during reset guarantees no stray datapath writes.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = bus.mem_ready;
          ctrl.pc_write  = bus.mem_ready;
        end
        S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: ctrl.reg_write = 1'b1;
        default:   ctrl = '0;
      endcase
    end
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;

  assign illegal_op  = !reset && (state_reg == S_DECODE) && !op_is_legal(bus.opcode);
  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: reset, per-instruction tables,
// hand-written wait-state sequences and a randomized instruction stream.
module tb_multicycle_control;

  localparam int CW   = 4;
  localparam int MASK = (1 << CW) - 1;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } tb_ctrl_t;

  typedef struct {
    int st;
    bit rdy;
    bit retire;
    bit illegal;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         retired;
    bit         illegal;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    state;
  logic          illegal_op;
  logic [CW-1:0] instr_count;

  int n_pass = 0;
  int n_total = 0;
  int model_count = 0;
  step_t q[$];
  vec_t  vt[8];

  multicycle_control_if bus();

  multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  function automatic tb_ctrl_t act();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource};
  endfunction

  // Expected control bundle for each state, straight from the state table.
  function automatic tb_ctrl_t exp_ctrl(input int st, input bit rdy);
    tb_ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_J || op == T_ADDI;
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input int st, input bit rdy, input bit ret, input bit ill);
    step_t s;
    s.st = st; s.rdy = rdy; s.retire = ret; s.illegal = ill;
    q.push_back(s);
  endfunction

  // Reference: cycle-by-cycle schedule of one instruction, wf fetch waits, wm memory waits.
  function automatic void build(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) push(0, 1'b0, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0, 1'b0);
    push(1, rnd_bit(), 1'b0, !legal(op));
    case (op)
      T_R:    begin push(6, rnd_bit(), 0, 0); push(7, rnd_bit(), 1, 0); end
      T_ADDI: begin push(10, rnd_bit(), 0, 0); push(11, rnd_bit(), 1, 0); end
      T_BEQ:  push(8, rnd_bit(), 1, 0);
      T_J:    push(9, rnd_bit(), 1, 0);
      T_LW: begin
        push(2, rnd_bit(), 0, 0);
        for (int i = 0; i < wm; i++) push(3, 1'b0, 0, 0);
        push(3, 1'b1, 0, 0);
        push(4, rnd_bit(), 1, 0);
      end
      T_SW: begin
        push(2, rnd_bit(), 0, 0);
        for (int i = 0; i < wm; i++) push(5, 1'b0, 0, 0);
        push(5, 1'b1, 1, 0);
      end
      default: ;
    endcase
  endfunction

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    step_t s;
    int    n;
    build(op, wf, wm);
    n = q.size();
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.opcode    = op;
      bus.mem_ready = s.rdy;
      @(negedge clk);
      check("state", 32'(state), 32'(s.st));
      check("ctrl", {16'h0, act()}, {16'h0, exp_ctrl(s.st, s.rdy)});
      check("illegal_op", 32'(illegal_op), 32'(s.illegal));
      check("instr_count", 32'(instr_count), 32'(model_count & MASK));
      @(posedge clk);
      #1;
      if (s.retire) model_count++;
    end
    $display("instr op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d instr_count=%0d",
             op, wf, wm, n, instr_count);
  endtask

  // Independent latency measurement with mem_ready tied high.
  task automatic measure(input logic [5:0] op, output int cyc, output bit saw, output int delta);
    logic [CW-1:0] c0, d;
    c0  = instr_count;
    cyc = 0;
    saw = 1'b0;
    bus.opcode    = op;
    bus.mem_ready = 1'b1;
    do begin
      @(negedge clk);
      if (illegal_op) saw = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end while (state != 4'd0 && cyc < 20);
    d     = instr_count - c0;
    delta = int'(d);
  endtask

  initial begin
    int  cyc, delta;
    bit  saw;
    int  kind, wf, wm;
    logic [5:0] op;

    vt[0] = '{T_R,     4, 1, 1'b0};
    vt[1] = '{T_LW,    5, 1, 1'b0};
    vt[2] = '{T_SW,    4, 1, 1'b0};
    vt[3] = '{T_BEQ,   3, 1, 1'b0};
    vt[4] = '{T_J,     3, 1, 1'b0};
    vt[5] = '{T_ADDI,  4, 1, 1'b0};
    vt[6] = '{6'b111111, 2, 0, 1'b1};
    vt[7] = '{6'b000001, 2, 0, 1'b1};

    // Reset held: everything low even with mem_ready high.
    bus.opcode    = T_LW;
    bus.mem_ready = 1'b1;
    #7;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", {16'h0, act()}, 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_fetch_state", 32'(state), 32'd0);
    check("first_fetch_ctrl", {16'h0, act()}, {16'h0, exp_ctrl(0, 1'b1)});
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Hand sequences: R, lw with two memory waits, sw, beq, j, addi, illegal.
    run_instr(T_R, 0, 0);
    run_instr(T_LW, 0, 2);
    run_instr(T_SW, 0, 0);
    run_instr(T_BEQ, 0, 0);
    run_instr(T_J, 0, 0);
    run_instr(T_ADDI, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(T_SW, 1, 2);

    // Table: zero-wait latency, retire count, illegal flag.
    foreach (vt[i]) begin
      measure(vt[i].op, cyc, saw, delta);
      check("tbl_cycles", 32'(cyc), 32'(vt[i].cycles));
      check("tbl_retired", 32'(delta), 32'(vt[i].retired));
      check("tbl_illegal", 32'(saw), 32'(vt[i].illegal));
      model_count += vt[i].retired;
      $display("vector op=%b cycles=%0d retired=%0d illegal=%0d", vt[i].op, cyc, delta, saw);
    end

    // Randomized instruction stream with random wait states.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      wf   = $urandom_range(0, 2);
      wm   = $urandom_range(0, 2);
      case (kind)
        0: op = T_R;
        1: op = T_LW;
        2: op = T_SW;
        3: op = T_BEQ;
        4: op = T_J;
        5: op = T_ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, wf, wm);
    end

    // Reset asserted in the middle of a waiting MEM_READ.
    bus.opcode    = T_LW;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_state", 32'(state), 32'd3);
    check("pre_rst_mem", {30'h0, bus.MemRead, bus.IorD}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_ctrl", {16'h0, act()}, 32'd0);
    check("async_rst_count", 32'(instr_count), 32'd0);
    model_count   = 0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    check("held_rst_ctrl", {16'h0, act()}, 32'd0);
    check("held_rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", {16'h0, act()}, {16'h0, exp_ctrl(0, 1'b1)});
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Counter wrap: bring it to all-ones, then retire one more.
    while ((model_count & MASK) != MASK) run_instr(T_J, 0, 0);
    check("count_all_ones", 32'(instr_count), 32'(MASK));
    run_instr(T_BEQ, 0, 0);
    check("count_wrap", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
